// File: rtl/spi_rx_module.sv
// SPI receive path: synchronised SCLK/CS/MISO to MSB-first bytes, buffered in a circular FIFO popped by Read_RQ.
// Byte enters FIFO one Mclk after its 8th sample; pop data valid one cycle after Read_RQ; push into a full FIFO drops the byte and sets Overrun.
module spi_rx_module #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 4
) (
    input  logic                  Mclk,
    input  logic                  nReset,
    input  logic                  SPI_clk,
    input  logic                  SPI_CS,
    input  logic                  SPI_MISO,
    input  logic                  Read_RQ,
    input  logic                  Clear_Ovr,
    output logic [DATA_WIDTH-1:0] Data_Out,
    output logic                  Data_Valid,
    output logic                  rx_empty,
    output logic                  rx_full,
    output logic [ADDR_W:0]       rx_usedw,
    output logic                  Overrun
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_STORE = 2'd2;

    logic clk_s1, clk_s2, clk_prev;
    logic cs_s1, cs_s2;
    logic miso_s1, miso_s2;
    logic sclk_rise;

    logic [1:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shreg;

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     wptr, rptr;
    logic                  push, pop, wr_en, ovr_set;
    logic [ADDR_W:0]       cnt_next;

    // CS sync resets high so a reset never looks like a select.
    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            clk_s1   <= 1'b0;
            clk_s2   <= 1'b0;
            clk_prev <= 1'b0;
            cs_s1    <= 1'b1;
            cs_s2    <= 1'b1;
            miso_s1  <= 1'b0;
            miso_s2  <= 1'b0;
        end else begin
            clk_s1   <= SPI_clk;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            cs_s1    <= SPI_CS;
            cs_s2    <= cs_s1;
            miso_s1  <= SPI_MISO;
            miso_s2  <= miso_s1;
        end
    end

    assign sclk_rise = clk_s2 & ~clk_prev;

    // A sample in the same cycle as CS rising takes priority, so a completed 8th bit is kept.
    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (!cs_s2) state <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (sclk_rise) begin
                        shreg   <= {shreg[DATA_WIDTH-2:0], miso_s2};
                        bit_cnt <= bit_cnt + CW'(1);
                        if (bit_cnt == CW'(DATA_WIDTH - 1)) state <= S_STORE;
                    end else if (cs_s2) begin
                        bit_cnt <= '0;
                        state   <= S_IDLE;
                    end
                end
                S_STORE: begin
                    bit_cnt <= '0;
                    state   <= cs_s2 ? S_IDLE : S_SHIFT;
                end
                default: begin
                    bit_cnt <= '0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

    // A concurrent pop frees the slot, so a push into a full FIFO still lands.
    assign push    = (state == S_STORE);
    assign pop     = Read_RQ & ~rx_empty;
    assign wr_en   = push & (~rx_full | pop);
    assign ovr_set = push & rx_full & ~pop;

    always_comb begin
        cnt_next = rx_usedw;
        if (wr_en && !pop)      cnt_next = rx_usedw + (ADDR_W+1)'(1);
        else if (pop && !wr_en) cnt_next = rx_usedw - (ADDR_W+1)'(1);
    end

    always_ff @(posedge Mclk) begin
        if (wr_en) mem[wptr] <= shreg;
    end

    always_ff @(posedge Mclk or negedge nReset) begin
        if (!nReset) begin
            wptr       <= '0;
            rptr       <= '0;
            Data_Out   <= '0;
            Data_Valid <= 1'b0;
            rx_usedw   <= '0;
            rx_empty   <= 1'b1;
            rx_full    <= 1'b0;
            Overrun    <= 1'b0;
        end else begin
            Data_Valid <= pop;
            if (wr_en) wptr <= wptr + ADDR_W'(1);
            if (pop) begin
                Data_Out <= mem[rptr];
                rptr     <= rptr + ADDR_W'(1);
            end
            rx_usedw <= cnt_next;
            rx_empty <= (cnt_next == '0);
            rx_full  <= (cnt_next == (ADDR_W+1)'(FIFO_DEPTH));
            if (ovr_set)        Overrun <= 1'b1;
            else if (Clear_Ovr) Overrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_spi_rx_module.sv
// Directed bench for spi_rx_module: table of single-byte transfers plus hand-built corner sequences.
module tb_spi_rx_module;

    logic       Mclk = 1'b0;
    logic       nReset;
    logic       SPI_clk, SPI_CS, SPI_MISO, Read_RQ, Clear_Ovr;
    logic [7:0] Data_Out;
    logic       Data_Valid, rx_empty, rx_full, Overrun;
    logic [4:0] rx_usedw;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] exp_data;
        logic [4:0] exp_used;
    } vec_t;

    vec_t vecs [6];

    spi_rx_module #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .ADDR_W(4)) dut (
        .Mclk(Mclk), .nReset(nReset), .SPI_clk(SPI_clk), .SPI_CS(SPI_CS),
        .SPI_MISO(SPI_MISO), .Read_RQ(Read_RQ), .Clear_Ovr(Clear_Ovr),
        .Data_Out(Data_Out), .Data_Valid(Data_Valid), .rx_empty(rx_empty),
        .rx_full(rx_full), .rx_usedw(rx_usedw), .Overrun(Overrun)
    );

    always #5 Mclk = ~Mclk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, got running want done");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge Mclk);
    endtask

    task automatic send_bit(input logic b);
        SPI_clk  = 1'b0;
        SPI_MISO = b;
        cyc(4);
        SPI_clk  = 1'b1;
        cyc(4);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) send_bit(b[i]);
    endtask

    task automatic cs_low;
        SPI_CS = 1'b0;
        cyc(3);
    endtask

    task automatic cs_high;
        SPI_clk = 1'b0;
        cyc(2);
        SPI_CS = 1'b1;
        cyc(6);
    endtask

    task automatic pop_chk(input string name, input logic [7:0] exp);
        Read_RQ = 1'b1;
        cyc(1);
        Read_RQ = 1'b0;
        chk({name, "_valid"}, 32'(Data_Valid), 32'd1);
        chk({name, "_data"}, 32'(Data_Out), 32'(exp));
        cyc(1);
        chk({name, "_valid_drop"}, 32'(Data_Valid), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_data"},  32'(Data_Out),   32'd0);
        chk({name, "_valid"}, 32'(Data_Valid), 32'd0);
        chk({name, "_empty"}, 32'(rx_empty),   32'd1);
        chk({name, "_full"},  32'(rx_full),    32'd0);
        chk({name, "_used"},  32'(rx_usedw),   32'd0);
        chk({name, "_ovr"},   32'(Overrun),    32'd0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 8'hA5, 5'd1};
        vecs[1] = '{8'h01, 8'h01, 5'd1};
        vecs[2] = '{8'h80, 8'h80, 5'd1};
        vecs[3] = '{8'hFF, 8'hFF, 5'd1};
        vecs[4] = '{8'h00, 8'h00, 5'd1};
        vecs[5] = '{8'h5A, 8'h5A, 5'd1};

        nReset = 1'b0; SPI_clk = 1'b0; SPI_CS = 1'b1; SPI_MISO = 1'b0;
        Read_RQ = 1'b0; Clear_Ovr = 1'b0;
        cyc(3);
        chk_reset_outputs("reset");
        nReset = 1'b1;
        cyc(3);

        // Single-byte transfers: usedw 0 -> 1 -> 0, one-cycle valid pulse.
        for (int i = 0; i < 6; i++) begin
            cs_low();
            send_bits(vecs[i].tx, 8);
            cs_high();
            chk("vec_used", 32'(rx_usedw), 32'(vecs[i].exp_used));
            chk("vec_empty", 32'(rx_empty), 32'd0);
            pop_chk("vec_pop", vecs[i].exp_data);
            chk("vec_used_after", 32'(rx_usedw), 32'd0);
        end

        // Back-to-back bytes under one CS.
        cs_low();
        send_bits(8'h01, 8);
        send_bits(8'h80, 8);
        send_bits(8'hFF, 8);
        cs_high();
        chk("b2b_used", 32'(rx_usedw), 32'd3);
        pop_chk("b2b_0", 8'h01);
        pop_chk("b2b_1", 8'h80);
        pop_chk("b2b_2", 8'hFF);
        chk("b2b_empty", 32'(rx_empty), 32'd1);

        // Aborted partial byte is discarded.
        cs_low();
        send_bits(8'hE7, 5);
        cs_high();
        chk("abort_used", 32'(rx_usedw), 32'd0);
        cs_low();
        send_bits(8'h3C, 8);
        cs_high();
        chk("abort_used_after", 32'(rx_usedw), 32'd1);
        pop_chk("abort_pop", 8'h3C);

        // 17 bytes into a 16-deep FIFO: 17th dropped, overrun sticky.
        cs_low();
        for (int i = 1; i <= 17; i++) send_bits(8'(i), 8);
        cs_high();
        chk("ovf_full", 32'(rx_full), 32'd1);
        chk("ovf_used", 32'(rx_usedw), 32'd16);
        chk("ovf_ovr", 32'(Overrun), 32'd1);
        for (int i = 1; i <= 16; i++) pop_chk("ovf_pop", 8'(i));
        chk("ovf_empty", 32'(rx_empty), 32'd1);
        chk("ovf_ovr_held", 32'(Overrun), 32'd1);
        Clear_Ovr = 1'b1;
        cyc(1);
        Clear_Ovr = 1'b0;
        chk("ovf_ovr_clr", 32'(Overrun), 32'd0);

        // Full FIFO with a pop in the STORE cycle: push lands, no overrun.
        cs_low();
        for (int i = 0; i < 16; i++) send_bits(8'h20 + 8'(i), 8);
        chk("fp_full", 32'(rx_full), 32'd1);
        send_bits(8'h99, 7);
        SPI_clk  = 1'b0;
        SPI_MISO = 1'b1;
        cyc(4);
        SPI_clk = 1'b1;
        cyc(3);
        Read_RQ = 1'b1;
        cyc(1);
        Read_RQ = 1'b0;
        chk("fp_valid", 32'(Data_Valid), 32'd1);
        chk("fp_data", 32'(Data_Out), 32'h20);
        chk("fp_used", 32'(rx_usedw), 32'd16);
        chk("fp_ovr", 32'(Overrun), 32'd0);
        cs_high();
        chk("fp_ovr_late", 32'(Overrun), 32'd0);
        for (int i = 1; i < 16; i++) pop_chk("fp_pop", 8'h20 + 8'(i));
        pop_chk("fp_pop_last", 8'h99);
        chk("fp_empty", 32'(rx_empty), 32'd1);

        // Read on empty is ignored.
        Read_RQ = 1'b1;
        cyc(1);
        Read_RQ = 1'b0;
        chk("empty_rd_valid", 32'(Data_Valid), 32'd0);
        chk("empty_rd_data", 32'(Data_Out), 32'h99);
        chk("empty_rd_used", 32'(rx_usedw), 32'd0);

        // Reset mid-byte with entries queued.
        cs_low();
        for (int i = 0; i < 4; i++) send_bits(8'h40 + 8'(i), 8);
        send_bits(8'hFF, 4);
        chk("rst_pre_used", 32'(rx_usedw), 32'd4);
        nReset  = 1'b0;
        SPI_CS  = 1'b1;
        SPI_clk = 1'b0;
        cyc(2);
        chk_reset_outputs("rst_mid");
        nReset = 1'b1;
        cyc(3);
        cs_low();
        send_bits(8'hC3, 8);
        cs_high();
        chk("rst_post_used", 32'(rx_usedw), 32'd1);
        pop_chk("rst_post_pop", 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_rx_module.md
# spi_rx_module

SPI receive path for the Mclk-domain SPI link. Samples `SPI_MISO` on rising edges of the divided SPI clock while `SPI_CS` is low and assembles MSB-first bytes. Completed bytes go into an internal receive FIFO, which the host drains with a `Read_RQ`/`Data_Valid` handshake. It sits beside the transmit chain (tx FIFO, mux, shift register) and shares its `csi_clk`/`CS` signals.

## Interface
- `DATA_WIDTH`, 8: bits per SPI word.
- `FIFO_DEPTH`, 16: receive FIFO entries; must be a power of two.
- `ADDR_W`, 4: log2(`FIFO_DEPTH`).
- `Mclk`  in  1: system clock; the only clock.
- `nReset`  in  1: asynchronous reset, active low.
- `SPI_clk`  in  1: divided SPI clock (`csi_clk`); sampled as data, never used as a clock.
- `SPI_CS`  in  1: chip select, active low; sampled as data.
- `SPI_MISO`  in  1: serial data from the slave.
- `Read_RQ`  in  1: one-cycle pop request from the host.
- `Clear_Ovr`  in  1: clears the sticky `Overrun` flag.
- `Data_Out`  out  `DATA_WIDTH`: last byte popped.
- `Data_Valid`  out  1: one-cycle pulse; `Data_Out` is new this cycle.
- `rx_empty`  out  1: FIFO holds 0 entries.
- `rx_full`  out  1: FIFO holds `FIFO_DEPTH` entries.
- `rx_usedw`  out  `ADDR_W`+1: entry count, 0..`FIFO_DEPTH`.
- `Overrun`  out  1: sticky; a completed byte was dropped because the FIFO was full.

## Operation
- **Input synchronisers:** `SPI_clk`, `SPI_CS` and `SPI_MISO` each pass through a 2-flop synchroniser. One more register on `SPI_clk` gives rising-edge detection (`sclk_rise` = sync & ~prev).
- **FSM states:** IDLE, SHIFT, STORE.
  - IDLE: bit counter = 0. On synced CS = 0, go to SHIFT.
  - SHIFT: on each `sclk_rise`, do shreg = {shreg[6:0], miso_sync} and increment the bit counter.
    - On the 8th sample, go to STORE.
    - If synced CS goes to 1 before the 8th sample, discard the partial byte, clear the counter and go to IDLE. Nothing is written.
  - STORE, one cycle: push shreg into the FIFO, clear the counter.
    - If CS is still 0, return to SHIFT for back-to-back bytes; otherwise go to IDLE.
- **FIFO:** circular buffer with `ADDR_W`-bit read/write pointers that wrap at `FIFO_DEPTH`-1 → 0. Separate `rx_usedw` counter.
- **Push when full:** byte dropped, `Overrun` set to 1 and held until a `Clear_Ovr` pulse. If set and clear happen in the same cycle, set wins.
- **Pop:** `Read_RQ`=1 and `rx_empty`=0 → `Data_Out` <= mem[rptr], rptr++, `Data_Valid`=1 for one cycle. `Read_RQ` on empty is ignored: no pulse, `Data_Out` holds.
- **Simultaneous push and pop:** both happen and `rx_usedw` is unchanged. This holds even when full, so the push is not dropped and `Overrun` is not set.
- **Flags:** `rx_empty`, `rx_full`, `rx_usedw` are registered and reflect the count after the current cycle's push/pop.

## Timing
- **Reset values:** `Data_Out`=0, `Data_Valid`=0, `rx_empty`=1, `rx_full`=0, `rx_usedw`=0, `Overrun`=0. Also FSM=IDLE, pointers=0, synchronisers=0 except CS sync=1.
- **Reset mid-operation:** `nReset` low aborts immediately. The partial byte and all FIFO contents are lost.
- **Sample latency:** a `SPI_clk` rising edge at the pins is sampled on the 3rd `Mclk` rising edge after it. `SPI_MISO` stays aligned because it uses a synchroniser of the same depth.
- **Input timing constraints:**
  - `SPI_clk` high and low phases ≥ 3 `Mclk` cycles each.
  - `SPI_MISO` stable ≥ 3 `Mclk` cycles around each `SPI_clk` rise.
  - Violating these is outside spec.
- **Byte to FIFO:** the FIFO write happens in the STORE cycle, 1 `Mclk` after the 8th `sclk_rise` cycle. `rx_usedw` updates at the end of that cycle.
- **Pop latency:** `Read_RQ` at edge N → `Data_Out`/`Data_Valid` valid after edge N+1. Back-to-back `Read_RQ` pops one entry per cycle.
- **CS deassert timing:** if CS rises in the same cycle as the 8th `sclk_rise`, the byte is complete and is stored.

## Test plan
- Reset, then CS low, 8 SPI clocks with MISO = 0xA5 MSB first, then one `Read_RQ` → `rx_usedw` 0→1→0, `Data_Out`=0xA5, `Data_Valid` high exactly 1 cycle.
- Three back-to-back bytes 0x01, 0x80, 0xFF under one CS low → three pops return 0x01, 0x80, 0xFF in order; `rx_empty`=1 afterwards.
- CS raised after 5 bits, then a full byte 0x3C → only 0x3C stored, `rx_usedw`=1.
- 17 bytes received with no reads (`FIFO_DEPTH`=16) → `rx_full`=1, `Overrun`=1, 16 pops return bytes 1..16 (17th lost), pointers wrap. `Clear_Ovr` → `Overrun`=0.
- FIFO full plus `Read_RQ` in the byte's STORE cycle → `rx_usedw` stays 16, `Overrun` stays 0. `Read_RQ` on empty → no `Data_Valid`.
- `nReset` pulsed low mid-byte with 4 entries queued → all outputs at reset values. The next full byte is received correctly.
